// File: rtl/ibuf_router.sv
// rtl/ibuf_router.sv - banked input buffer with row/bank/column read routing
module ibuf_router #(
    parameter int DW   = 32,
    parameter int POY  = 3,
    parameter int BUFH = 2,
    parameter int BUFW = 32,
    parameter int BW   = (POY  > 1) ? $clog2(POY)  : 1,
    parameter int RW   = (BUFH > 1) ? $clog2(BUFH) : 1,
    parameter int CW   = (BUFW > 1) ? $clog2(BUFW) : 1,
    parameter int CNTW = $clog2(POY*BUFH+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DW-1:0]          wr_data,
    input  logic [BW-1:0]          wr_bank,
    input  logic [RW-1:0]          wr_row,
    input  logic [CW-1:0]          wr_col,
    input  logic                   wr_last,
    input  logic                   rd_req,
    input  logic [1:0]             rd_mode,
    input  logic [BW-1:0]          rd_bank,
    input  logic [RW-1:0]          rd_row,
    input  logic [CW-1:0]          rd_col,
    input  logic                   rd_release,
    output logic                   rd_gnt,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [POY*BUFW*DW-1:0] rd_data,
    output logic                   rd_err,
    output logic [CNTW-1:0]        row_cnt
);

    localparam int NROW = POY * BUFH;
    localparam logic [1:0] MODE_RR = 2'b00;
    localparam logic [1:0] MODE_BR = 2'b01;
    localparam logic [1:0] MODE_RP = 2'b10;
    localparam logic [1:0] MODE_NE = 2'b11;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [NROW-1:0]          full_q, full_d;
    logic [CNTW-1:0]          row_cnt_q, row_cnt_d;
    logic [POY*BUFW*DW-1:0]   rd_data_q, rd_data_d;
    logic                     rd_err_q, rd_err_d;
    logic [DW-1:0]            mem_q [POY][BUFH][BUFW];

    logic [NROW-1:0]          wr_hit, rd_tgt, set_mask, clr_mask;
    logic                     wr_accept, rd_bad, rows_ok, out_free, legal_gnt;

    // Decode the write address into a one-hot row; out-of-range addresses hit nothing
    always_comb begin
        wr_hit = '0;
        if (int'(wr_col) < BUFW) begin
            for (int b = 0; b < POY; b++) begin
                for (int r = 0; r < BUFH; r++) begin
                    if (int'(wr_bank) == b && int'(wr_row) == r) wr_hit[b*BUFH+r] = 1'b1;
                end
            end
        end
    end

    assign wr_ready  = |(wr_hit & ~full_q);
    assign wr_accept = wr_valid && wr_ready;

    // Decode the read request: rows it touches and whether it is illegal
    always_comb begin
        rd_tgt = '0;
        rd_bad = 1'b0;
        if (rd_mode == MODE_NE) rd_bad = 1'b1;
        if (rd_mode == MODE_BR && int'(rd_bank) >= POY) rd_bad = 1'b1;
        if (int'(rd_row) >= BUFH) rd_bad = 1'b1;
        if (rd_mode == MODE_RP && int'(rd_col) >= BUFW) rd_bad = 1'b1;
        for (int b = 0; b < POY; b++) begin
            for (int r = 0; r < BUFH; r++) begin
                if (int'(rd_row) == r && (rd_mode != MODE_BR || int'(rd_bank) == b))
                    rd_tgt[b*BUFH+r] = 1'b1;
            end
        end
    end

    // Illegal requests are consumed as soon as the output is free so they never block
    assign rows_ok   = ((rd_tgt & full_q) == rd_tgt);
    assign out_free  = (state_q == EMPTY) || rd_ready;
    assign rd_gnt    = rst_n && rd_req && out_free && (rd_bad || rows_ok);
    assign legal_gnt = rd_gnt && !rd_bad;

    // Full-flag bookkeeping, row count and output handshake state
    always_comb begin
        set_mask  = (wr_accept && wr_last) ? wr_hit : '0;
        clr_mask  = (legal_gnt && rd_release) ? rd_tgt : '0;
        full_d    = (full_q | set_mask) & ~clr_mask;
        row_cnt_d = row_cnt_q + CNTW'($countones(set_mask)) - CNTW'($countones(clr_mask));
        rd_err_d  = rd_gnt && rd_bad;
        state_d   = state_q;
        case (state_q)
            EMPTY:   if (legal_gnt) state_d = FULL;
            FULL:    if (rd_ready && !legal_gnt) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Route the selected array elements into the output slices on a legal grant
    always_comb begin
        rd_data_d = rd_data_q;
        if (legal_gnt) begin
            for (int b = 0; b < POY; b++) begin
                for (int r = 0; r < BUFH; r++) begin
                    for (int c = 0; c < BUFW; c++) begin
                        if (int'(rd_row) == r) begin
                            case (rd_mode)
                                MODE_RR: rd_data_d[(b*BUFW+c)*DW +: DW] = mem_q[b][r][c];
                                MODE_BR: if (int'(rd_bank) == b)
                                             rd_data_d[(b*BUFW+c)*DW +: DW] = mem_q[b][r][c];
                                MODE_RP: if (int'(rd_col) == c)
                                             rd_data_d[(b*BUFW+c)*DW +: DW] = mem_q[b][r][c];
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

    // Array storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < POY; b++) begin
                for (int r = 0; r < BUFH; r++) begin
                    for (int c = 0; c < BUFW; c++) begin
                        if (wr_hit[b*BUFH+r] && int'(wr_col) == c) mem_q[b][r][c] <= wr_data;
                    end
                end
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            full_q    <= '0;
            row_cnt_q <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            row_cnt_q <= row_cnt_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rd_valid = (state_q == FULL);
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign row_cnt  = row_cnt_q;

endmodule

// File: tb/tb_ibuf_router.sv
// tb/tb_ibuf_router.sv - directed self-checking bench for ibuf_router
module tb_ibuf_router;

    localparam int DW = 32, POY = 3, BUFH = 2, BUFW = 4;
    localparam int BW = 2, RW = 1, CW = 2, CNTW = 3;
    localparam int OW = POY*BUFW*DW;
    localparam logic [1:0] RR = 2'b00, BR = 2'b01, RP = 2'b10, NE = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_valid, wr_ready, wr_last;
    logic [DW-1:0]   wr_data;
    logic [BW-1:0]   wr_bank;
    logic [RW-1:0]   wr_row;
    logic [CW-1:0]   wr_col;
    logic            rd_req, rd_release, rd_gnt, rd_valid, rd_ready, rd_err;
    logic [1:0]      rd_mode;
    logic [BW-1:0]   rd_bank;
    logic [RW-1:0]   rd_row;
    logic [CW-1:0]   rd_col;
    logic [OW-1:0]   rd_data;
    logic [CNTW-1:0] row_cnt;

    ibuf_router #(.DW(DW), .POY(POY), .BUFH(BUFH), .BUFW(BUFW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col), .wr_last(wr_last),
        .rd_req(rd_req), .rd_mode(rd_mode), .rd_bank(rd_bank), .rd_row(rd_row),
        .rd_col(rd_col), .rd_release(rd_release), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_err(rd_err), .row_cnt(row_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [POY][BUFH][BUFW];
    logic [31:0] out_m [POY][BUFW];

    typedef struct {
        logic [1:0] mode;
        int         bank;
        int         row;
        int         col;
        int         wbank;
        int         wrow;
        logic       exp_gnt;
        logic       exp_wrdy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, OW'(act), OW'(exp));
    endtask

    task automatic chkc(input string name, input int exp);
        check(name, OW'(row_cnt), OW'(exp));
    endtask

    function automatic logic [OW-1:0] pack_out();
        logic [OW-1:0] v;
        v = '0;
        for (int b = 0; b < POY; b++)
            for (int c = 0; c < BUFW; c++)
                v[(b*BUFW+c)*DW +: DW] = out_m[b][c];
        return v;
    endfunction

    task automatic clear_out();
        for (int b = 0; b < POY; b++)
            for (int c = 0; c < BUFW; c++)
                out_m[b][c] = '0;
    endtask

    task automatic load(input logic [1:0] m, input int b, input int r, input int col);
        for (int bb = 0; bb < POY; bb++)
            for (int cc = 0; cc < BUFW; cc++) begin
                if (m == RR) out_m[bb][cc] = mem_m[bb][r][cc];
                else if (m == BR && bb == b) out_m[bb][cc] = mem_m[bb][r][cc];
                else if (m == RP && cc == col) out_m[bb][cc] = mem_m[bb][r][cc];
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int r, input int c, input logic [31:0] d,
                      input logic last, input logic exp_rdy);
        wr_valid = 1'b1; wr_bank = 2'(b); wr_row = 1'(r); wr_col = 2'(c);
        wr_data = d; wr_last = last;
        #2;
        chk1("wr_ready", wr_ready, exp_rdy);
        if (exp_rdy) mem_m[b][r][c] = d;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic fill_row(input int b, input int r, input logic [31:0] base);
        for (int c = 0; c < BUFW; c++)
            wr(b, r, c, base + 32'(c), (c == BUFW-1), 1'b1);
    endtask

    task automatic rd(input logic [1:0] m, input int b, input int r, input int c,
                      input logic rel, input logic exp_g, input logic ld, input string name);
        rd_req = 1'b1; rd_mode = m; rd_bank = 2'(b); rd_row = 1'(r); rd_col = 2'(c);
        rd_release = rel;
        #2;
        chk1(name, rd_gnt, exp_g);
        tick();
        rd_req = 1'b0; rd_release = 1'b0;
        if (ld) load(m, b, r, c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{RR, 0, 0, 0, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{RR, 0, 1, 0, 0, 1, 1'b0, 1'b1};
        vecs[2] = '{BR, 1, 0, 0, 3, 0, 1'b1, 1'b0};
        vecs[3] = '{BR, 2, 1, 0, 2, 1, 1'b0, 1'b1};
        vecs[4] = '{RP, 0, 0, 2, 2, 0, 1'b1, 1'b0};
        vecs[5] = '{RP, 0, 1, 3, 1, 1, 1'b0, 1'b1};
        vecs[6] = '{NE, 0, 0, 0, 1, 0, 1'b1, 1'b0};
        vecs[7] = '{BR, 3, 1, 0, 3, 1, 1'b1, 1'b0};

        rst_n = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        wr_bank = '0; wr_row = '0; wr_col = '0;
        rd_req = 1'b0; rd_mode = RR; rd_bank = '0; rd_row = '0; rd_col = '0;
        rd_release = 1'b0; rd_ready = 1'b1;
        clear_out();

        #12;
        chk1("reset rd_valid", rd_valid, 1'b0);
        chk1("reset rd_err", rd_err, 1'b0);
        chk1("reset rd_gnt", rd_gnt, 1'b0);
        chkc("reset row_cnt", 0);
        check("reset rd_data", rd_data, '0);
        rst_n = 1'b1;
        tick();

        // Row 0 of every bank, then the grant/write-ready table against that state
        for (int b = 0; b < POY; b++) fill_row(b, 0, 32'(b*16));
        chkc("row_cnt after fill", 3);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            rd_req = 1'b1; rd_mode = vecs[i].mode; rd_bank = 2'(vecs[i].bank);
            rd_row = 1'(vecs[i].row); rd_col = 2'(vecs[i].col);
            wr_bank = 2'(vecs[i].wbank); wr_row = 1'(vecs[i].wrow); wr_col = '0;
            #2;
            chk1($sformatf("vec%0d rd_gnt", i), rd_gnt, vecs[i].exp_gnt);
            chk1($sformatf("vec%0d wr_ready", i), wr_ready, vecs[i].exp_wrdy);
            rd_req = 1'b0;
        end
        tick();
        chkc("row_cnt after table", 3);

        rd(RR, 0, 0, 0, 1'b1, 1'b1, 1'b1, "rr row0 gnt");
        chk1("rr rd_valid", rd_valid, 1'b1);
        check("rr rd_data", rd_data, pack_out());
        chkc("rr row_cnt", 0);
        tick();
        chk1("rr drain rd_valid", rd_valid, 1'b0);

        // Only bank 1 row 1 full: RR waits, BR goes
        fill_row(1, 1, 32'h100);
        chkc("bank1 row_cnt", 1);
        rd_req = 1'b1; rd_mode = RR; rd_row = 1'b1; rd_release = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk1("rr row1 waits", rd_gnt, 1'b0);
            tick();
        end
        rd_req = 1'b0; rd_release = 1'b0;
        chk1("rr waited rd_valid", rd_valid, 1'b0);
        rd(BR, 1, 1, 0, 1'b1, 1'b1, 1'b1, "br b1r1 gnt");
        check("br rd_data", rd_data, pack_out());
        chkc("br row_cnt", 0);
        tick();

        // RR of row 0, then RP column 2 of row 1
        for (int b = 0; b < POY; b++) fill_row(b, 0, 32'h200 + 32'(b*16));
        for (int b = 0; b < POY; b++) fill_row(b, 1, 32'h300 + 32'(b*16));
        chkc("all rows full", 6);
        rd(RR, 0, 0, 0, 1'b1, 1'b1, 1'b1, "rr2 gnt");
        check("rr2 rd_data", rd_data, pack_out());
        rd(RP, 0, 1, 2, 1'b1, 1'b1, 1'b1, "rp gnt");
        chk1("rp rd_valid", rd_valid, 1'b1);
        check("rp rd_data", rd_data, pack_out());
        chkc("rp row_cnt", 0);
        tick();

        // Output stall with a second request held
        rd_ready = 1'b0;
        for (int b = 0; b < POY; b++) fill_row(b, 0, 32'h400 + 32'(b*16));
        for (int b = 0; b < POY; b++) fill_row(b, 1, 32'h500 + 32'(b*16));
        rd(RR, 0, 0, 0, 1'b1, 1'b1, 1'b1, "stall first gnt");
        rd_req = 1'b1; rd_mode = RR; rd_row = 1'b1; rd_release = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall no gnt", rd_gnt, 1'b0);
            chk1("stall rd_valid", rd_valid, 1'b1);
            check("stall rd_data", rd_data, pack_out());
            tick();
        end
        rd_ready = 1'b1;
        #1;
        chk1("stall release gnt", rd_gnt, 1'b1);
        tick();
        rd_req = 1'b0; rd_release = 1'b0;
        load(RR, 0, 1, 0);
        chk1("b2b rd_valid", rd_valid, 1'b1);
        check("b2b rd_data", rd_data, pack_out());
        chkc("b2b row_cnt", 0);
        tick();
        chk1("b2b drained", rd_valid, 1'b0);

        // Write to a full row, then illegal requests
        fill_row(0, 1, 32'h600);
        wr(0, 1, 1, 32'hdead, 1'b0, 1'b0);
        rd(NE, 0, 1, 0, 1'b1, 1'b1, 1'b0, "ne gnt");
        chk1("ne rd_err", rd_err, 1'b1);
        chk1("ne rd_valid", rd_valid, 1'b0);
        chkc("ne row_cnt", 1);
        tick();
        chk1("ne rd_err pulse", rd_err, 1'b0);
        rd(BR, 3, 1, 0, 1'b1, 1'b1, 1'b0, "br oor gnt");
        chk1("br oor rd_err", rd_err, 1'b1);
        chk1("br oor rd_valid", rd_valid, 1'b0);
        chkc("br oor row_cnt", 1);
        tick();
        rd(BR, 0, 1, 0, 1'b1, 1'b1, 1'b1, "br full-row gnt");
        check("full-row data intact", rd_data, pack_out());
        chkc("full-row row_cnt", 0);
        tick();

        // Asynchronous reset while holding output with two rows full
        fill_row(0, 0, 32'h700);
        fill_row(1, 0, 32'h710);
        fill_row(2, 1, 32'h720);
        rd_ready = 1'b0;
        rd(BR, 2, 1, 0, 1'b1, 1'b1, 1'b1, "pre-reset gnt");
        chk1("pre-reset rd_valid", rd_valid, 1'b1);
        chkc("pre-reset row_cnt", 2);
        #2;
        rd_req = 1'b1; rd_mode = NE;
        rst_n = 1'b0;
        #1;
        chk1("async rd_valid", rd_valid, 1'b0);
        chkc("async row_cnt", 0);
        check("async rd_data", rd_data, '0);
        chk1("async rd_gnt", rd_gnt, 1'b0);
        tick();
        rd_req = 1'b0;
        rst_n = 1'b1;
        rd_ready = 1'b1;
        clear_out();
        tick();
        rd(RR, 0, 0, 0, 1'b0, 1'b0, 1'b0, "post-reset no gnt");
        chk1("post-reset rd_valid", rd_valid, 1'b0);
        wr(0, 0, 0, 32'h1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibuf_router.md
IBUF_ROUTER -- requirements
Module: ibuf_router

Interface
REQ-001 SHALL have parameters, one per line:
- DW, 32, element width in bits
- POY, 3, bank count (output rows in parallel)
- BUFH, 2, rows per bank
- BUFW, 32, columns per row
- BW/RW/CW, derived as clog2(POY)/clog2(BUFH)/clog2(BUFW), min 1
REQ-002 SHALL have ports, one per line, name direction width meaning:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write element offered
- wr_ready  out  1  write accepted this cycle when high with wr_valid
- wr_data  in  DW  element
- wr_bank  in  BW  target bank
- wr_row  in  RW  target row
- wr_col  in  CW  target column
- wr_last  in  1  accepted write completes row (wr_bank, wr_row)
- rd_req  in  1  read request, held until rd_gnt
- rd_mode  in  2  00 RR, 01 BR, 10 RP, 11 NE (illegal)
- rd_bank  in  BW  bank for BR
- rd_row  in  RW  row for all modes
- rd_col  in  CW  column for RP
- rd_release  in  1  sampled with rd_gnt; frees rows read
- rd_gnt  out  1  request consumed this cycle
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  POY*BUFW*DW  bank b, column c at bits [(b*BUFW+c)*DW +: DW]
- rd_err  out  1  one-cycle pulse: illegal mode or out-of-range index
- row_cnt  out  clog2(POY*BUFH+1)  number of full rows

Function
REQ-003 SHALL keep a full flag per (bank,row); set on accepted write with wr_last; cleared on rd_gnt with rd_release for each row read.
REQ-004 SHALL drive wr_ready = !full[wr_bank][wr_row] and wr_bank<POY; an out-of-range wr_bank is never accepted (wr_ready=0).
REQ-005 SHALL store wr_data in the array on the edge of an accepted write; no read-back hazard exists, since writes target only non-full rows and reads only full rows.
REQ-006 SHALL grant (rd_gnt=1) when rd_req and (!rd_valid or rd_ready) and the mode's rows are full:
- RR/RP: full[b][rd_row] for all b
- BR: full[rd_bank][rd_row]
REQ-007 SHALL grant NE, and rd_bank>=POY in BR, as soon as output is free, without row checks; rd_err pulses one cycle after grant, rd_valid stays 0, and no full flags change.
REQ-008 SHALL present data one cycle after grant (rd_valid=1):
- RR: every bank's rd_row row loaded into its output slice
- BR: only bank rd_bank's slice loaded; others unchanged
- RP: only column rd_col of every bank loaded; other columns unchanged
REQ-009 SHALL hold rd_data and rd_valid while rd_valid and !rd_ready; rd_valid clears after the rd_ready handshake unless a new grant occurs that cycle (back-to-back, throughput 1/cycle).
REQ-010 SHALL implement output FSM states EMPTY (rd_valid=0) and FULL (rd_valid=1):
- EMPTY->FULL on legal grant
- FULL->EMPTY on rd_ready with no legal grant
- FULL->FULL on stall or on rd_ready with a legal grant
REQ-011 SHALL update row_cnt each cycle by sets minus clears; a set and a clear on different rows in the same cycle leave it unchanged.
REQ-012 SHALL keep a rd_req held across stall cycles unmodified by the requester (protocol rule on the driver; bench checks it).

Reset
REQ-013 SHALL, on rst_n low, asynchronously clear all full flags, rd_valid, rd_gnt, rd_err, row_cnt, rd_data and the FSM (EMPTY); array contents need not reset.
REQ-014 SHALL discard an in-flight grant or held output when reset asserts mid-operation; the first grant after release follows REQ-006 from empty.

Verification
REQ-015 SHALL cover, one scenario each:
- POY=3, BUFW=4: fill row 0 of all banks with b*16+c, wr_last on c=3 -> RR rd_row=0 grants; next cycle rd_valid=1, slice(b,c)=b*16+c; row_cnt 3->0 with release.
- Fill only bank 1 row 1 -> RR row 1 waits (rd_gnt=0); BR bank1 row1 grants; only bank 1 slice changes.
- RP rd_col=2 after RR with different row data -> only column 2 of each bank changes.
- rd_ready=0 for 3 cycles with second request pending -> rd_data stable, no second grant; rd_ready=1 -> second grant same cycle, rd_valid stays 1.
- Write to full row -> wr_ready=0, array unchanged; NE request -> rd_gnt then rd_err one pulse, rd_valid 0.
- rst_n low during FULL with row_cnt=2 -> rd_valid=0, row_cnt=0 immediately, no clk edge needed.
